alu_result_fifo: RTL and testbench
==================================

// Module: alu_result_fifo
// PURPOSE
//   Downstream stage of the 4-bit ALU: captures each {carry_flag, result} pair the ALU produces and buffers it
//   in a DEPTH-entry FIFO. Consumers (display/checker/bus master) drain it via valid/ready at their own pace.
//   The ALU has no backpressure, so pushes while full are dropped and reported by a sticky overflow flag.
// PARAMETERS
//   DATA_W  4  width of ALU result field
//   DEPTH   8  FIFO entries; power of 2, >= 2
//   CNT_W   $clog2(DEPTH)+1  width of occupancy count (localparam, derived)
// PORTS
//   clk         in   1       system clock, rising edge
//   rst_n       in   1       asynchronous active-low reset
//   in_valid    in   1       ALU result valid this cycle (push request)
//   in_result   in   DATA_W  ALU result
//   in_carry    in   1       ALU carry_flag
//   in_ready    out  1       FIFO not full
//   out_valid   out  1       head entry available
//   out_ready   in   1       consumer accepts head entry
//   out_result  out  DATA_W  head result; 0 when out_valid=0
//   out_carry   out  1       head carry; 0 when out_valid=0
//   count       out  CNT_W   current occupancy, 0..DEPTH
//   overflow    out  1       sticky: a push was dropped because the FIFO was full
//   clr_ovf     in   1       synchronous clear of overflow
// BEHAVIOUR
//   - Reset (async, rst_n=0): wr_ptr=rd_ptr=0, count=0, overflow=0, out_valid=0, in_ready=1, out_* = 0.
//     Storage array is not reset. Reset mid-operation discards all contents immediately.
//   - Storage: DEPTH x (DATA_W+1) registers, entry = {carry, result}. Pointers wrap modulo DEPTH.
//   - push = in_valid & in_ready; pop = out_valid & out_ready. Both sample on the rising clk edge.
//   - in_ready = (count != DEPTH); combinational from registered count, NOT pop-aware.
//   - out_valid = (count != 0); first-word fall-through: head visible combinationally from storage at rd_ptr.
//   - Latency: entry pushed at edge N is on out_* with out_valid=1 after edge N (visible in cycle N+1).
//   - count: +1 on push only, -1 on pop only, unchanged on push&pop or neither.
//   - Empty + push + out_ready: no pop that cycle (out_valid was 0); entry appears next cycle.
//   - Full + in_valid: push dropped even if a pop occurs in the same cycle; overflow <= 1.
//   - overflow: set on dropped push, cleared by clr_ovf; set wins if both occur in the same cycle.
//   - No state machine beyond pointers/count; all outputs derived from registered state.
// CONFIGURATION
//   ALU_FIFO_CARRY_CNT_EN defined: adds output carry_cnt [7:0], counts accepted pushes with in_carry=1;
//     saturates at 8'hFF; reset 0; cleared together with overflow by clr_ovf (a push with carry in the
//     same cycle as clr_ovf leaves carry_cnt=1).
//   Undefined: carry_cnt port and counter absent; all other behaviour identical.
// TESTING
//   1. Reset: rst_n=0 -> out_valid=0, in_ready=1, count=0, overflow=0, out_result=0, out_carry=0.
//   2. Push {0,4'hA} (5+5) then {1,4'h4} (13+7), out_ready=0 -> count=2, head {0,A};
//      out_ready=1 two cycles -> pops A then 4, count=0, out_valid=0.
//   3. Push 8 entries 0..7, out_ready=0 -> count=8, in_ready=0; 9th push 4'hF -> dropped, overflow=1;
//      drain returns 0..7 in order; clr_ovf=1 -> overflow=0.
//   4. Fill to 3 entries, then push&pop every cycle for 20 cycles -> count stays 3, data in order,
//      pointers wrap past DEPTH with no loss.
//   5. Fill to 5, assert rst_n=0 mid-cycle -> count=0, out_valid=0 immediately, before next clk edge.
//   6. With ALU_FIFO_CARRY_CNT_EN: push carries 1,0,1,1 -> carry_cnt=3; 300 carry pushes with
//      draining -> carry_cnt=8'hFF.

Source files
------------

// File: rtl/alu_result_fifo_if.sv
// Handshake bundle between the ALU result producer, the result FIFO and its consumer.
// The slave modport is the FIFO's view; the master modport is the producer/consumer view.
interface alu_result_fifo_if #(
  parameter int DATA_W = 4
);
  logic              in_valid;
  logic [DATA_W-1:0] in_result;
  logic              in_carry;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic              out_carry;

  modport master (
    output in_valid, in_result, in_carry, out_ready,
    input  in_ready, out_valid, out_result, out_carry
  );

  modport slave (
    input  in_valid, in_result, in_carry, out_ready,
    output in_ready, out_valid, out_result, out_carry
  );
endinterface

// File: rtl/alu_result_fifo.sv
// First-word fall-through FIFO buffering {carry, result} pairs from the ALU, with sticky drop flag.
// Optional ALU_FIFO_CARRY_CNT_EN adds a saturating count of accepted pushes that carried.
module alu_result_fifo #(
  parameter  int DATA_W = 4,
  parameter  int DEPTH  = 8,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_result_fifo_if.slave bus,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  input  logic             clr_ovf
`ifdef ALU_FIFO_CARRY_CNT_EN
  ,
  output logic [7:0]       carry_cnt
`endif
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W:0]    mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               overflow_q, overflow_d;
  logic               full, empty, push, pop, drop;
  logic [DATA_W:0]    head;

  // Readiness looks only at registered occupancy, so a full FIFO drops even if it pops this cycle.
  always_comb begin
    full       = (count_q == FULL_CNT);
    empty      = (count_q == '0);
    push       = bus.in_valid & ~full;
    pop        = ~empty & bus.out_ready;
    drop       = bus.in_valid & full;
    head       = mem_q[rd_ptr_q];
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (clr_ovf) overflow_d = 1'b0;
    if (drop)    overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage holds no reset: contents are meaningless whenever count says the slot is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.in_carry, bus.in_result};
  end

  assign bus.in_ready   = ~full;
  assign bus.out_valid  = ~empty;
  assign bus.out_result = empty ? '0 : head[DATA_W-1:0];
  assign bus.out_carry  = ~empty & head[DATA_W];
  assign count          = count_q;
  assign overflow       = overflow_q;

`ifdef ALU_FIFO_CARRY_CNT_EN
  logic [7:0] carry_cnt_q, carry_cnt_d;

  // A clear that coincides with a carrying push restarts the count at one rather than zero.
  always_comb begin
    carry_cnt_d = carry_cnt_q;
    if (clr_ovf) begin
      carry_cnt_d = (push & bus.in_carry) ? 8'd1 : 8'd0;
    end else if (push && bus.in_carry && carry_cnt_q != 8'hFF) begin
      carry_cnt_d = carry_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) carry_cnt_q <= 8'd0;
    else        carry_cnt_q <= carry_cnt_d;
  end

  assign carry_cnt = carry_cnt_q;
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed, table-driven bench for alu_result_fifo; hand-written sequences cover wrap, async reset
// and the optional carry counter (ALU_FIFO_CARRY_CNT_EN).
module tb_alu_result_fifo;

  logic       clk;
  logic       rst_n;
  logic       clr_ovf;
  logic [3:0] count;
  logic       overflow;
`ifdef ALU_FIFO_CARRY_CNT_EN
  logic [7:0] carry_cnt;
`endif

  int nCompared;
  int nMismatched;

  alu_result_fifo_if #(.DATA_W(4)) bus ();

  alu_result_fifo #(.DATA_W(4), .DEPTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .count    (count),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
`ifdef ALU_FIFO_CARRY_CNT_EN
    ,
    .carry_cnt(carry_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       vin;
    logic [3:0] res;
    logic       car;
    logic       ordy;
    logic       clr;
    logic       ev;
    logic [3:0] eres;
    logic       ecar;
    int         ecnt;
    logic       erdy;
    logic       eovf;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic vin, input logic [3:0] res, input logic car, input logic ordy,
                        input logic clr, input logic ev, input logic [3:0] eres, input logic ecar,
                        input int ecnt, input logic erdy, input logic eovf);
    vec_t v;
    v = '{vin, res, car, ordy, clr, ev, eres, ecar, ecnt, erdy, eovf};
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, take the rising edge, and return 1ns after it for sampling.
  task automatic applyStimulus(input logic vin, input logic [3:0] res, input logic car,
                               input logic ordy, input logic clr);
    bus.in_valid  = vin;
    bus.in_result = res;
    bus.in_carry  = car;
    bus.out_ready = ordy;
    clr_ovf       = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    nCompared++;
    if (act != exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkAll(input string tag, input logic ev, input logic [3:0] eres, input logic ecar,
                          input int ecnt, input logic erdy, input logic eovf);
    checkOutput($sformatf("%s.out_valid", tag), int'(bus.out_valid), int'(ev));
    checkOutput($sformatf("%s.out_result", tag), int'(bus.out_result), int'(eres));
    checkOutput($sformatf("%s.out_carry", tag), int'(bus.out_carry), int'(ecar));
    checkOutput($sformatf("%s.count", tag), int'(count), ecnt);
    checkOutput($sformatf("%s.in_ready", tag), int'(bus.in_ready), int'(erdy));
    checkOutput($sformatf("%s.overflow", tag), int'(overflow), int'(eovf));
  endtask

  initial begin
    int expRes;
    int expCar;
    nCompared   = 0;
    nMismatched = 0;

    // Two results, then two pops; an empty FIFO with out_ready set must not pop the fresh entry.
    addVec(1, 4'hA, 0, 0, 0,  1, 4'hA, 0, 1, 1, 0);
    addVec(1, 4'h4, 1, 0, 0,  1, 4'hA, 0, 2, 1, 0);
    addVec(0, 4'h0, 0, 1, 0,  1, 4'h4, 1, 1, 1, 0);
    addVec(0, 4'h0, 0, 1, 0,  0, 4'h0, 0, 0, 1, 0);
    addVec(1, 4'h3, 0, 1, 0,  1, 4'h3, 0, 1, 1, 0);
    addVec(0, 4'h0, 0, 1, 0,  0, 4'h0, 0, 0, 1, 0);
    // Fill with 0..7, carry = bit 0; head stays entry 0.
    for (int i = 0; i < 8; i++)
      addVec(1, 4'(i), i[0], 0, 0,  1, 4'h0, 0, i + 1, (i != 7), 0);
    // Dropped push while full, then a drop alongside a pop.
    addVec(1, 4'hF, 1, 0, 0,  1, 4'h0, 0, 8, 0, 1);
    addVec(1, 4'hE, 0, 1, 0,  1, 4'h1, 1, 7, 1, 1);
    addVec(1, 4'hD, 0, 0, 0,  1, 4'h1, 1, 8, 0, 1);
    // Drop and clear in the same cycle: the drop wins.
    addVec(1, 4'hC, 0, 0, 1,  1, 4'h1, 1, 8, 0, 1);
    addVec(0, 4'h0, 0, 1, 1,  1, 4'h2, 0, 7, 1, 0);
    for (int i = 2; i < 8; i++) begin
      if (i < 7) addVec(0, 4'h0, 0, 1, 0,  1, 4'(i + 1), ((i + 1) % 2 == 1), 8 - i, 1, 0);
      else       addVec(0, 4'h0, 0, 1, 0,  1, 4'hD, 0, 1, 1, 0);
    end
    addVec(0, 4'h0, 0, 1, 0,  0, 4'h0, 0, 0, 1, 0);

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_result = 4'h0;
    bus.in_carry  = 1'b0;
    bus.out_ready = 1'b0;
    clr_ovf       = 1'b0;
    #12;
    checkAll("reset", 0, 4'h0, 0, 0, 1, 0);
`ifdef ALU_FIFO_CARRY_CNT_EN
    checkOutput("reset.carry_cnt", int'(carry_cnt), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].vin, vecs[i].res, vecs[i].car, vecs[i].ordy, vecs[i].clr);
      checkAll($sformatf("vec%0d", i), vecs[i].ev, vecs[i].eres, vecs[i].ecar, vecs[i].ecnt,
               vecs[i].erdy, vecs[i].eovf);
    end

    // Steady push&pop at occupancy 3; 23 writes wrap the pointers several times.
    // Entry j carries value (j+1)&15; the three prefill entries have carry 0, later ones (j-3)&1.
    for (int j = 0; j < 3; j++) applyStimulus(1, 4'(j + 1), 0, 0, 0);
    checkAll("prefill", 1, 4'h1, 0, 3, 1, 0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 4'((i + 4) & 15), ((i % 2) == 1), 1, 0);
      expRes = (i + 2) & 15;
      expCar = (i + 1 < 3) ? 0 : ((i + 1 - 3) & 1);
      checkAll($sformatf("stream%0d", i), 1, 4'(expRes), expCar[0], 3, 1, 0);
    end
    for (int j = 0; j < 3; j++) applyStimulus(0, 4'h0, 0, 1, 0);
    checkAll("stream_drained", 0, 4'h0, 0, 0, 1, 0);

    // Asynchronous reset mid-cycle clears outputs before the next clock edge.
    for (int j = 0; j < 5; j++) applyStimulus(1, 4'(j + 9), 1, 0, 0);
    checkAll("fill5", 1, 4'h9, 1, 5, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checkAll("async_reset", 0, 4'h0, 0, 0, 1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 4'h0, 0, 1, 0);
    checkAll("after_reset", 0, 4'h0, 0, 0, 1, 0);

`ifdef ALU_FIFO_CARRY_CNT_EN
    checkOutput("cc.after_reset", int'(carry_cnt), 0);
    applyStimulus(1, 4'h1, 1, 1, 0);
    applyStimulus(1, 4'h2, 0, 1, 0);
    applyStimulus(1, 4'h3, 1, 1, 0);
    applyStimulus(1, 4'h4, 1, 1, 0);
    checkOutput("cc.pattern", int'(carry_cnt), 3);
    applyStimulus(1, 4'h5, 1, 1, 1);
    checkOutput("cc.clear_with_push", int'(carry_cnt), 1);
    for (int i = 0; i < 300; i++) applyStimulus(1, 4'(i), 1, 1, 0);
    checkOutput("cc.saturate", int'(carry_cnt), 255);
    applyStimulus(0, 4'h0, 0, 1, 1);
    checkOutput("cc.clear", int'(carry_cnt), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
